// File: rtl/fetch_stream_queue.sv
// fetch_stream_queue: in-order queue of predicted fetch streams between predictor, fetch unit and backend.
module fetch_stream_queue #(
    parameter int DEPTH   = 16,
    parameter int VADDR_W = 32,
    parameter int SIZE_W  = 4,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pred_en,
    input  logic [VADDR_W-1:0] pred_start,
    input  logic [VADDR_W-1:0] pred_target,
    input  logic [SIZE_W-1:0]  pred_size,
    input  logic               pred_taken,
    input  logic               pred_redirect,
    input  logic [IDX_W-1:0]   redirect_idx,
    output logic               stall,
    output logic [IDX_W-1:0]   stream_idx,
    output logic               stream_dir,
    output logic               squash,
    output logic [VADDR_W-1:0] squash_target,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [IDX_W-1:0]   fetch_idx,
    output logic [VADDR_W-1:0] fetch_start,
    output logic [VADDR_W-1:0] fetch_target,
    output logic [SIZE_W-1:0]  fetch_size,
    output logic               fetch_taken,
    output logic               fetch_flush,
    input  logic               be_squash,
    input  logic [IDX_W-1:0]   be_squash_idx,
    input  logic [VADDR_W-1:0] be_squash_target,
    input  logic               commit_valid
);
    logic [IDX_W:0]       wr_ptr, fe_ptr, cm_ptr, wr_nx, fe_nx, wr_prev, sq_wr;
    logic [IDX_W-1:0]     sq_nidx, wr_idx;
    logic [VADDR_W-1:0]   start_q [DEPTH];
    logic [VADDR_W-1:0]   target_q [DEPTH];
    logic [SIZE_W-1:0]    size_q [DEPTH];
    logic                 taken_q [DEPTH];
    logic                 enq, redir, fire, rewind;
    assign wr_idx      = wr_ptr[IDX_W-1:0];
    assign stall       = (wr_idx == cm_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != cm_ptr[IDX_W]);
    assign stream_idx  = wr_idx;
    assign stream_dir  = wr_ptr[IDX_W];
    assign enq         = pred_en & ~stall & ~pred_redirect & ~be_squash & ~squash;
    assign redir       = pred_en & pred_redirect & ~stall & ~be_squash & ~squash;
    assign fetch_valid = (fe_ptr != wr_ptr) & ~squash;
    assign fire        = fetch_valid & fetch_ready & ~be_squash;
    assign fetch_idx   = fe_ptr[IDX_W-1:0];
    assign fetch_start  = start_q[fetch_idx];
    assign fetch_target = target_q[fetch_idx];
    assign fetch_size   = size_q[fetch_idx];
    assign fetch_taken  = taken_q[fetch_idx];
    assign wr_prev     = wr_ptr - 1'b1;
    assign rewind      = redir & ((fe_ptr == wr_ptr) | (fire & (fetch_idx == redirect_idx)));
    // The surviving entry is live, so a wrapped or equal index lies one lap past the head.
    assign sq_nidx     = be_squash_idx + 1'b1;
    assign sq_wr       = {cm_ptr[IDX_W] ^ (sq_nidx <= cm_ptr[IDX_W-1:0]), sq_nidx};
    always_comb begin
        wr_nx = be_squash ? sq_wr : enq ? wr_ptr + 1'b1 : wr_ptr;
        fe_nx = be_squash ? sq_wr : rewind ? wr_prev : fire ? fe_ptr + 1'b1 : fe_ptr;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            fe_ptr        <= '0;
            cm_ptr        <= '0;
            squash        <= 1'b0;
            squash_target <= '0;
            fetch_flush   <= 1'b0;
        end else begin
            wr_ptr        <= wr_nx;
            fe_ptr        <= fe_nx;
            cm_ptr        <= commit_valid ? cm_ptr + 1'b1 : cm_ptr;
            squash        <= be_squash;
            squash_target <= be_squash ? be_squash_target : squash_target;
            fetch_flush   <= rewind;
        end
    end
    always_ff @(posedge clk) begin
        if (be_squash) begin
            target_q[be_squash_idx] <= be_squash_target;
            taken_q[be_squash_idx]  <= 1'b1;
        end else if (redir | enq) begin
            start_q[redir ? redirect_idx : wr_idx]  <= pred_start;
            target_q[redir ? redirect_idx : wr_idx] <= pred_target;
            size_q[redir ? redirect_idx : wr_idx]   <= pred_size;
            taken_q[redir ? redirect_idx : wr_idx]  <= pred_taken;
        end
    end
endmodule

// File: tb/tb_fetch_stream_queue.sv
// tb_fetch_stream_queue: scoreboard bench; every fetch handshake is compared against the expected stream.
module tb_fetch_stream_queue;
    logic        clk = 0, rst = 1;
    logic        pred_en = 0, pred_taken = 0, pred_redirect = 0;
    logic [31:0] pred_start = 0, pred_target = 0, squash_target, fetch_start, fetch_target;
    logic [3:0]  pred_size = 0, redirect_idx = 0, stream_idx, fetch_idx, fetch_size, be_squash_idx = 0;
    logic        stall, stream_dir, squash, fetch_valid, fetch_ready = 0, fetch_taken, fetch_flush;
    logic        be_squash = 0, commit_valid = 0;
    logic [31:0] be_squash_target = 0;
    typedef struct {logic [31:0] s; logic [31:0] t; logic [3:0] z; logic k; logic [3:0] i;} ent_t;
    ent_t sb[$];
    int checks = 0, errors = 0, m_wr = 0;
    always #5 clk = ~clk;
    fetch_stream_queue dut (
        .clk(clk), .rst(rst), .pred_en(pred_en), .pred_start(pred_start), .pred_target(pred_target),
        .pred_size(pred_size), .pred_taken(pred_taken), .pred_redirect(pred_redirect),
        .redirect_idx(redirect_idx), .stall(stall), .stream_idx(stream_idx), .stream_dir(stream_dir),
        .squash(squash), .squash_target(squash_target), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_idx(fetch_idx), .fetch_start(fetch_start), .fetch_target(fetch_target), .fetch_size(fetch_size),
        .fetch_taken(fetch_taken), .fetch_flush(fetch_flush), .be_squash(be_squash),
        .be_squash_idx(be_squash_idx), .be_squash_target(be_squash_target), .commit_valid(commit_valid)
    );
    task automatic tick();
        ent_t e;
        if (fetch_valid && fetch_ready && !be_squash && !rst) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL fetch_order: unexpected stream idx=%0d start=%h", fetch_idx, fetch_start);
            end else begin
                e = sb.pop_front();
                if ({fetch_idx, fetch_start, fetch_target, fetch_size, fetch_taken} !== {e.i, e.s, e.t, e.z, e.k}) begin
                    errors++;
                    $display("FAIL fetch_stream: got idx=%0d s=%h t=%h z=%0d k=%b want idx=%0d s=%h t=%h z=%0d k=%b",
                             fetch_idx, fetch_start, fetch_target, fetch_size, fetch_taken, e.i, e.s, e.t, e.z, e.k);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic enq(input logic [31:0] s, input logic [31:0] t, input logic [3:0] z, input logic k, input bit acc);
        pred_en = 1; pred_redirect = 0; pred_start = s; pred_target = t; pred_size = z; pred_taken = k;
        if (acc) begin
            sb.push_back('{s, t, z, k, 4'(m_wr)});
            m_wr++;
        end
        tick();
        pred_en = 0;
    endtask
    task automatic redirect(input logic [3:0] idx, input logic [31:0] s, input logic [31:0] t, input bit rew);
        pred_en = 1; pred_redirect = 1; redirect_idx = idx; pred_start = s; pred_target = t; pred_size = 4'd7; pred_taken = 1;
        if (rew) sb.push_back('{s, t, 4'd7, 1'b1, idx});
        else sb[sb.size()-1] = '{s, t, 4'd7, 1'b1, idx};
        tick();
        pred_en = 0; pred_redirect = 0;
    endtask
    task automatic do_reset();
        rst = 1; pred_en = 0; fetch_ready = 0; be_squash = 0; commit_valid = 0;
        tick();
        rst = 0; sb.delete(); m_wr = 0;
    endtask
    task automatic test_reset();
        do_reset();
        checks++;
        if ({stall, stream_idx, stream_dir, squash, squash_target, fetch_valid, fetch_flush} !== '0) begin
            errors++;
            $display("FAIL reset_state: stall=%b idx=%0d dir=%b squash=%b tgt=%h fv=%b ff=%b",
                     stall, stream_idx, stream_dir, squash, squash_target, fetch_valid, fetch_flush);
        end
    endtask
    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (stream_idx !== 4'(i) || stall !== 1'b0) begin
                errors++;
                $display("FAIL fill_idx: idx=%0d stall=%b want idx=%0d stall=0", stream_idx, stall, i);
            end
            enq(32'h100 + 32'(i * 16), 32'h200 + 32'(i), 4'(i), i[0], 1);
        end
        checks++;
        if (stall !== 1'b1 || stream_idx !== 4'd0 || stream_dir !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: stall=%b idx=%0d dir=%b want 1/0/1", stall, stream_idx, stream_dir);
        end
        enq(32'hdead, 32'hbeef, 4'd1, 1'b0, 0);
        checks++;
        if (stall !== 1'b1 || stream_idx !== 4'd0) begin
            errors++;
            $display("FAIL ignored_enq: stall=%b idx=%0d want 1/0", stall, stream_idx);
        end
        fetch_ready = 1;
        tick();
        fetch_ready = 0;
        commit_valid = 1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL commit_same_cycle: stall=%b want 1", stall);
        end
        tick();
        commit_valid = 0;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL commit_frees: stall=%b want 0", stall);
        end
    endtask
    task automatic test_fetch();
        do_reset();
        fetch_ready = 1;
        pred_en = 1; pred_start = 32'h1000;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: fetch_valid=%b want 0", fetch_valid);
        end
        enq(32'h1000, 32'h1020, 4'd3, 1'b1, 1);
        checks++;
        if (fetch_valid !== 1'b1 || fetch_start !== 32'h1000 || fetch_idx !== 4'd0) begin
            errors++;
            $display("FAIL first_fetch: fv=%b start=%h idx=%0d want 1/1000/0", fetch_valid, fetch_start, fetch_idx);
        end
        tick();
        fetch_ready = 0;
    endtask
    task automatic test_redirect();
        do_reset();
        fetch_ready = 1;
        for (int i = 0; i < 4; i++) enq(32'h1000 + 32'(i * 256), 32'h1100 + 32'(i * 256), 4'(i), 1'b0, 1);
        tick();
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained: fetch_valid=%b want 0", fetch_valid);
        end
        redirect(4'd3, 32'h1300, 32'h2000, 1);
        checks++;
        if (fetch_flush !== 1'b1 || stream_idx !== 4'd4 || fetch_valid !== 1'b1 || fetch_idx !== 4'd3 || fetch_target !== 32'h2000) begin
            errors++;
            $display("FAIL redirect_rewind: ff=%b widx=%0d fv=%b fidx=%0d tgt=%h want 1/4/1/3/2000",
                     fetch_flush, stream_idx, fetch_valid, fetch_idx, fetch_target);
        end
        tick();
        checks++;
        if (fetch_flush !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pulse: ff=%b fv=%b want 0/0", fetch_flush, fetch_valid);
        end
        fetch_ready = 0;
        enq(32'h1400, 32'h1480, 4'd2, 1'b0, 1);
        fetch_ready = 1;
        redirect(4'd4, 32'h1400, 32'h2400, 1);
        checks++;
        if (fetch_flush !== 1'b1 || fetch_idx !== 4'd4 || fetch_target !== 32'h2400) begin
            errors++;
            $display("FAIL redirect_handshake: ff=%b fidx=%0d tgt=%h want 1/4/2400", fetch_flush, fetch_idx, fetch_target);
        end
        tick();
        fetch_ready = 0;
        enq(32'h1500, 32'h1580, 4'd2, 1'b0, 1);
        redirect(4'd5, 32'h1500, 32'h2500, 0);
        checks++;
        if (fetch_flush !== 1'b0 || stream_idx !== 4'd6) begin
            errors++;
            $display("FAIL redirect_unfetched: ff=%b widx=%0d want 0/6", fetch_flush, stream_idx);
        end
        fetch_ready = 1;
        tick();
        fetch_ready = 0;
    endtask
    task automatic test_squash();
        do_reset();
        for (int i = 0; i < 8; i++) enq(32'h3000 + 32'(i * 64), 32'h3040 + 32'(i * 64), 4'd1, 1'b0, 1);
        be_squash = 1; be_squash_idx = 4'd5; be_squash_target = 32'h3000;
        pred_en = 1; pred_start = 32'hbad0;
        tick();
        be_squash = 0;
        sb.delete(); m_wr = 6;
        checks++;
        if (squash !== 1'b1 || squash_target !== 32'h3000 || stream_idx !== 4'd6 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL squash_cycle: sq=%b tgt=%h widx=%0d fv=%b want 1/3000/6/0", squash, squash_target, stream_idx, fetch_valid);
        end
        tick();
        pred_en = 0;
        checks++;
        if (squash !== 1'b0 || stream_idx !== 4'd6 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL squash_after: sq=%b widx=%0d fv=%b want 0/6/0", squash, stream_idx, fetch_valid);
        end
        fetch_ready = 1;
        enq(32'h3000, 32'h3100, 4'd2, 1'b0, 1);
        tick();
        fetch_ready = 0;
    endtask
    task automatic test_back_to_back();
        do_reset();
        fetch_ready = 1;
        for (int i = 0; i < 20; i++) begin
            commit_valid = (i >= 2);
            checks++;
            if (stream_idx !== 4'(i % 16) || stream_dir !== (i >= 16) || stall !== 1'b0) begin
                errors++;
                $display("FAIL wrap_step %0d: idx=%0d dir=%b stall=%b", i, stream_idx, stream_dir, stall);
            end
            enq(32'h5000 + 32'(i * 32), 32'h5020 + 32'(i * 32), 4'(i), i[1], 1);
        end
        commit_valid = 0;
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain: %0d streams never fetched, want 0", sb.size());
        end
        fetch_ready = 0;
    endtask
    task automatic test_rst_squash();
        do_reset();
        enq(32'h6000, 32'h6040, 4'd1, 1'b0, 1);
        enq(32'h6040, 32'h6080, 4'd1, 1'b0, 1);
        be_squash = 1; be_squash_idx = 4'd0; be_squash_target = 32'h4000; rst = 1;
        tick();
        be_squash = 0; rst = 0; sb.delete(); m_wr = 0;
        checks++;
        if ({stall, stream_idx, stream_dir, squash, squash_target, fetch_valid, fetch_flush} !== '0) begin
            errors++;
            $display("FAIL rst_squash: stall=%b idx=%0d dir=%b sq=%b tgt=%h fv=%b ff=%b",
                     stall, stream_idx, stream_dir, squash, squash_target, fetch_valid, fetch_flush);
        end
        fetch_ready = 1;
        enq(32'h7000, 32'h7040, 4'd1, 1'b0, 1);
        tick();
        rst = 1;
        redirect(4'd0, 32'h7000, 32'h7777, 1);
        rst = 0; sb.delete(); m_wr = 0;
        checks++;
        if (fetch_flush !== 1'b0 || squash !== 1'b0 || fetch_valid !== 1'b0 || stream_idx !== 4'd0) begin
            errors++;
            $display("FAIL rst_flush: ff=%b sq=%b fv=%b idx=%0d want 0/0/0/0", fetch_flush, squash, fetch_valid, stream_idx);
        end
        fetch_ready = 0;
    endtask
    initial begin
        test_reset();
        test_fill();
        test_fetch();
        test_redirect();
        test_squash();
        test_back_to_back();
        test_rst_squash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stream_queue.md
# fetch_stream_queue

Fetch stream queue (FSQ) sitting directly downstream of the branch predictor. It:
- accepts one predicted fetch stream per cycle;
- lets the predictor's second stage overwrite the most recently enqueued stream;
- hands streams in order to the instruction fetch unit and retires them on backend commit;
- rolls back on a backend squash and returns the corrected PC to the predictor.

## Interface
Parameters:
- DEPTH, 16, number of stream entries; power of two, ≥4
- VADDR_W, 32, virtual address width
- SIZE_W, 4, stream size field width (instruction-slot count minus one)
- IDX_W, $clog2(DEPTH), entry index width

Ports (clock and reset: one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pred_en  in  1  predictor offers a stream this cycle
- pred_start  in  VADDR_W  stream start address
- pred_target  in  VADDR_W  predicted next-stream PC
- pred_size  in  SIZE_W  stream size
- pred_taken  in  1  stream ends in a taken branch
- pred_redirect  in  1  stage-2 override; the offered stream replaces entry redirect_idx
- redirect_idx  in  IDX_W  entry being overridden
- stall  out  1  queue full; predictor holds its stage
- stream_idx  out  IDX_W  index the next allocated stream receives
- stream_dir  out  1  wrap/direction bit of that index
- squash  out  1  one-cycle flush to predictor
- squash_target  out  VADDR_W  PC the predictor restarts from
- fetch_valid  out  1  stream available to fetch
- fetch_ready  in  1  fetch unit accepts it
- fetch_idx  out  IDX_W  index of the offered stream
- fetch_start, fetch_target, fetch_size, fetch_taken  out  VADDR_W/VADDR_W/SIZE_W/1  entry fields
- fetch_flush  out  1  one-cycle pulse: discard in-flight fetch of the latest stream
- be_squash  in  1  backend misprediction
- be_squash_idx  in  IDX_W  mispredicted stream
- be_squash_target  in  VADDR_W  correct target
- commit_valid  in  1  retire the head stream

## Operation
State:
- Three (IDX_W+1)-bit pointers, index plus direction bit:
  - wr_ptr: next allocation
  - fe_ptr: next to fetch
  - cm_ptr: head
- Entry storage: start, target, size, taken.

Derived signals:
- full: index(wr_ptr) == index(cm_ptr) and the direction bits differ.
- stall = full, taken from registered state.
- stream_idx/stream_dir = wr_ptr.

Enqueue:
- Condition: pred_en & ~stall & ~pred_redirect & ~be_squash & ~squash.
- Action: write the entry at wr_ptr, then increment wr_ptr; the direction bit toggles on wrap.

Redirect:
- Condition: pred_en & pred_redirect & ~stall & ~be_squash & ~squash.
- Precondition: redirect_idx must equal index(wr_ptr−1).
- Action: overwrite that entry; wr_ptr is unchanged.
- Rewind: if fe_ptr == wr_ptr (entry already fetched), or a fetch handshake on redirect_idx happens in the same cycle:
  - fe_ptr ← wr_ptr−1;
  - fetch_flush pulses the next cycle.

Fetch:
- fetch_valid = (fe_ptr != wr_ptr) & ~squash.
- fetch_* shows the entry at fe_ptr.
- fe_ptr increments on fetch_valid & fetch_ready.

Commit:
- cm_ptr increments on commit_valid.
- The bench never commits past fe_ptr.

Backend squash:
- Entry be_squash_idx: target ← be_squash_target, taken ← 1.
- wr_ptr ← be_squash_idx+1, with the direction bit recomputed relative to cm_ptr.
- fe_ptr ← wr_ptr (new value).
- Next cycle: squash=1 and squash_target=be_squash_target.

Priority, highest first: rst > be_squash > redirect > enqueue. A fetch handshake is ignored in a be_squash cycle. Commit is independent and always honoured.

## Timing
Reset values:
- All pointers 0.
- stall 0, stream_idx 0, stream_dir 0.
- squash 0, squash_target 0.
- fetch_valid 0, fetch_flush 0.
- Entry contents are don't-care.

Latencies:
- An entry written in cycle N is offered on fetch_* in cycle N+1 at the earliest; there is no bypass.
- squash and fetch_flush are registered and last exactly one cycle.
- stall reflects the occupancy registered at the start of the cycle. A commit in the same cycle frees space only from the next cycle.

Boundary cases:
- Pointer wrap from DEPTH−1 to 0 toggles the direction bit.
- Empty: wr_ptr == cm_ptr. Full: index equal, direction bits differ.
- A rst asserted mid-operation restores reset state at the next edge; any pending squash or fetch_flush is dropped.

## Test plan
- Reset, then 16 enqueues with fetch_ready=0:
  - stream_idx steps 0..15;
  - stall=1 after the 16th enqueue;
  - a 17th pred_en is ignored;
  - one commit drops stall the following cycle.
- Enqueue a stream with start 0x1000 and target 0x1020, with fetch_ready=1:
  - fetch_valid rises the next cycle with fetch_start=0x1000, fetch_idx=0.
- Enqueue idx 3; fetch takes it; next cycle pred_redirect with redirect_idx=3 and target 0x2000:
  - entry 3 is rewritten;
  - fetch_flush pulses;
  - idx 3 is re-offered with target 0x2000;
  - wr_ptr stays at 4.
- With 8 entries live, be_squash with idx 5 and target 0x3000:
  - next cycle squash=1 and squash_target=0x3000;
  - stream_idx=6;
  - fetch_valid=0 during the squash cycle;
  - a simultaneous pred_en is dropped.
- Fill across the wrap with 20 enqueue/commit pairs:
  - stream_dir toggles at index 0;
  - stall never asserts;
  - fetch order matches enqueue order.
- Assert rst mid-stream while squash is pending:
  - all outputs return to reset values;
  - squash does not appear.
